// File: rtl/rom_rb_pkg.sv
// Shared definitions for the ROM readback block: the register map,
// the STATUS bit layout, the sequencer state type and a STATUS packing helper.
package rom_rb_pkg;

  // Avalon register offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_CKSUM  = 2'd3;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_ERR     = 3;
  localparam int STAT_LVL_LSB = 8;
  localparam int STAT_LVL_MSB = 15;

  // Readback sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    STALL = 2'd3
  } rb_state_t;

  // Assemble the STATUS word from its individual fields.
  function automatic logic [31:0] pack_status(
    input logic       busy,
    input logic       empty,
    input logic       full,
    input logic       err,
    input logic [7:0] level
  );
    logic [31:0] w;
    w                            = '0;
    w[STAT_BUSY]                 = busy;
    w[STAT_EMPTY]                = empty;
    w[STAT_FULL]                 = full;
    w[STAT_ERR]                  = err;
    w[STAT_LVL_MSB:STAT_LVL_LSB] = level;
    return w;
  endfunction

endpackage

// File: rtl/rom_rb_fifo.sv
// Synchronous show-ahead FIFO for captured ROM bytes.
// pop_data always presents the oldest entry; it is meaningless while empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; a pop from an empty FIFO is ignored.
module rom_rb_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [7:0]        level,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [7:0]        count;
  logic              do_push;
  logic              do_pop;

  assign do_pop   = pop && (count != 8'd0);
  assign do_push  = push && ((count != 8'(FIFO_DEPTH)) || do_pop);

  assign pop_data = mem[rd_ptr];
  assign level    = count;
  assign full     = (count == 8'(FIFO_DEPTH));
  assign empty    = (count == 8'd0);

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 8'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_readback.sv
// ROM readback engine: an Avalon-MM slave that reads a range of game ROM
// bytes through the NES-side ROM port, buffers them in a small FIFO for the
// NIOS to drain through the DATA register, and keeps a running 16-bit sum.
// Build option ROM_READBACK_CKSUM_EN: when defined, the checksum accumulator
// exists; when undefined, CKSUM reads 0 and CKSUM writes are ignored.
module rom_readback #(
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  AVL_ADDR,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  output logic [15:0] ROM_ADDR,
  output logic        ROM_RD,
  input  logic [7:0]  FROM_ROM
);

  import rom_rb_pkg::*;

  // Countdown reload: WAIT spans ROM_LATENCY cycles, the last one captures.
  localparam logic [1:0] LAT_RELOAD = 2'(ROM_LATENCY - 1);

  // Bus decode
  logic rd_en;
  logic wr_en;
  logic ctrl_wr;
  logic status_wr;
  logic data_rd;

  assign rd_en     = AVL_CS && AVL_READ;
  assign wr_en     = AVL_CS && AVL_WRITE;
  assign ctrl_wr   = wr_en && (AVL_ADDR == REG_CTRL);
  assign status_wr = wr_en && (AVL_ADDR == REG_STATUS);
  assign data_rd   = rd_en && (AVL_ADDR == REG_DATA);

  // Sequencer state
  rb_state_t   state;
  logic [15:0] addr;
  logic [15:0] remaining;
  logic [1:0]  wait_cnt;
  logic        rom_rd_r;
  logic [15:0] rom_addr_r;
  logic        err;

  logic        busy;
  logic        start_ok;
  logic        capture;

  assign busy     = (state != IDLE);
  assign start_ok = ctrl_wr && (state == IDLE) && (AVL_WRITEDATA[31:16] != 16'd0);
  assign capture  = (state == WAIT) && (wait_cnt == 2'd0);

  // FIFO interface
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_level;
  logic [7:0] fifo_head;
  logic       pop_eff;
  logic       full_after_push;

  assign pop_eff = data_rd && !fifo_empty;

  // The FIFO can never be full at capture time (a read is only issued into a
  // free slot), so it is full afterwards exactly when one slot was left and
  // the NIOS is not draining one in that same cycle.
  assign full_after_push = (fifo_level == 8'(FIFO_DEPTH - 1)) && !pop_eff;

  rom_rb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (8)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (capture),
    .push_data (FROM_ROM),
    .pop       (data_rd),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Readback sequencer: issues one ROM read per free FIFO slot and tracks address/remaining.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      addr       <= 16'd0;
      remaining  <= 16'd0;
      wait_cnt   <= 2'd0;
      rom_rd_r   <= 1'b0;
      rom_addr_r <= 16'd0;
    end else begin
      rom_rd_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            addr       <= AVL_WRITEDATA[15:0];
            remaining  <= AVL_WRITEDATA[31:16];
            state      <= ISSUE;
            rom_rd_r   <= 1'b1;
            rom_addr_r <= AVL_WRITEDATA[15:0];
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= LAT_RELOAD;
        end
        WAIT: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            addr      <= addr + 16'd1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= IDLE;
            end else if (full_after_push) begin
              state <= STALL;
            end else begin
              state      <= ISSUE;
              rom_rd_r   <= 1'b1;
              rom_addr_r <= addr + 16'd1;
            end
          end
        end
        STALL: begin
          if (!fifo_full) begin
            state      <= ISSUE;
            rom_rd_r   <= 1'b1;
            rom_addr_r <= addr;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ROM_RD   = rom_rd_r;
  assign ROM_ADDR = rom_addr_r;

  // Sticky error: a CTRL write that arrives while a transfer is running.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err <= 1'b0;
    end else if (ctrl_wr && busy) begin
      err <= 1'b1;
    end else if (status_wr) begin
      err <= 1'b0;
    end
  end

  logic [15:0] cksum_val;

`ifdef ROM_READBACK_CKSUM_EN
  logic        cksum_wr;
  logic [15:0] cksum;

  assign cksum_wr = wr_en && (AVL_ADDR == REG_CKSUM);

  // Modulo-2^16 accumulate of one captured byte.
  function automatic logic [15:0] cksum_acc(input logic [15:0] sum, input logic [7:0] b);
    return sum + {8'h00, b};
  endfunction

  // Running sum of captured bytes; a CKSUM write restarts it, keeping a byte captured that cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cksum <= 16'd0;
    end else if (cksum_wr) begin
      cksum <= capture ? cksum_acc(16'd0, FROM_ROM) : 16'd0;
    end else if (capture) begin
      cksum <= cksum_acc(cksum, FROM_ROM);
    end
  end

  assign cksum_val = cksum;
`else
  assign cksum_val = 16'd0;
`endif

  // DATA word: valid flag plus the head byte, all zero when nothing is buffered.
  logic        data_vld;
  logic [31:0] data_word;
  logic [31:0] avl_rdata_p1;

  assign data_vld  = !fifo_empty;
  assign data_word = {23'd0, data_vld, (data_vld ? fifo_head : 8'h00)};

  // Registered read port: the selected register is latched on the strobe and held until the next read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      avl_rdata_p1 <= 32'd0;
    end else if (rd_en) begin
      case (AVL_ADDR)
        REG_CTRL:   avl_rdata_p1 <= {remaining, addr};
        REG_STATUS: avl_rdata_p1 <= pack_status(busy, fifo_empty, fifo_full, err, fifo_level);
        REG_DATA:   avl_rdata_p1 <= data_word;
        default:    avl_rdata_p1 <= {16'd0, cksum_val};
      endcase
    end
  end

  assign AVL_READDATA = avl_rdata_p1;

endmodule

// File: tb/tb_rom_readback.sv
// Bench for rom_readback: two instances (ROM latency 1 and 3) share the
// clock; each gets its own bus, reset and ROM model and is exercised in turn.
`timescale 1ns/1ps
module tb_rom_readback;

  localparam int NU    = 2;
  localparam int DEPTH = 8;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_STATUS = 2'd1;
  localparam logic [1:0] R_DATA   = 2'd2;
  localparam logic [1:0] R_CKSUM  = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [NU];
  logic [1:0]  a_addr   [NU];
  logic        a_cs     [NU];
  logic        a_rd     [NU];
  logic        a_wr     [NU];
  logic [31:0] a_wd     [NU];
  logic [31:0] a_rdata  [NU];
  logic [15:0] rom_addr [NU];
  logic        rom_rd   [NU];
  logic [7:0]  from_rom [NU];

  int          rd_pulses [NU];
  int          iss_n     [NU];
  logic [15:0] iss_log   [NU][64];

  int          total = 0;
  int          bad   = 0;
  int          cur_u = 0;

  logic [7:0]  exp_q [$];
  logic [15:0] m_sum;

  // ROM contents as seen by the readback port
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_u
    localparam int LAT = (g == 0) ? 1 : 3;
    logic        rd_pipe [LAT];
    logic [15:0] ad_pipe [LAT];
    logic [7:0]  noise;

    rom_readback #(.ROM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .CLK           (clk),
      .RESET         (rst[g]),
      .AVL_ADDR      (a_addr[g]),
      .AVL_CS        (a_cs[g]),
      .AVL_READ      (a_rd[g]),
      .AVL_WRITE     (a_wr[g]),
      .AVL_WRITEDATA (a_wd[g]),
      .AVL_READDATA  (a_rdata[g]),
      .ROM_ADDR      (rom_addr[g]),
      .ROM_RD        (rom_rd[g]),
      .FROM_ROM      (from_rom[g])
    );

    // ROM model: data valid exactly LAT cycles after the strobe, random junk otherwise
    always @(posedge clk) begin
      noise      <= 8'($urandom);
      rd_pipe[0] <= rom_rd[g];
      ad_pipe[0] <= rom_addr[g];
      for (int k = 1; k < LAT; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
        ad_pipe[k] <= ad_pipe[k-1];
      end
      if (rom_rd[g]) begin
        rd_pulses[g]                 <= rd_pulses[g] + 1;
        iss_log[g][iss_n[g] % 64]    <= rom_addr[g];
        iss_n[g]                     <= iss_n[g] + 1;
      end
    end
    assign from_rom[g] = rd_pipe[LAT-1] ? rom_byte(ad_pipe[LAT-1]) : noise;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL u%0d %s got=%h exp=%h", cur_u, tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input int u, input logic [1:0] a, input logic [31:0] d);
    a_addr[u] = a; a_wd[u] = d; a_cs[u] = 1'b1; a_wr[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_cs[u] = 1'b0; a_wr[u] = 1'b0;
  endtask

  task automatic bus_rd(input int u, input logic [1:0] a, output logic [31:0] d);
    a_addr[u] = a; a_cs[u] = 1'b1; a_rd[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_cs[u] = 1'b0; a_rd[u] = 1'b0;
    d = a_rdata[u];
  endtask

  task automatic bus_rw(input int u, input logic [1:0] a, input logic [31:0] wd, output logic [31:0] d);
    a_addr[u] = a; a_wd[u] = wd; a_cs[u] = 1'b1; a_rd[u] = 1'b1; a_wr[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_cs[u] = 1'b0; a_rd[u] = 1'b0; a_wr[u] = 1'b0;
    d = a_rdata[u];
  endtask

  function automatic logic [31:0] exp_ck(input logic [15:0] s);
`ifdef ROM_READBACK_CKSUM_EN
    return {16'h0, s};
`else
    return 32'h0 & {16'h0, s};
`endif
  endfunction

  task automatic ck_clear(input int u);
    bus_wr(u, R_CKSUM, 32'h0);
    m_sum = 16'h0;
  endtask

  task automatic start(input int u, input logic [15:0] sa, input logic [15:0] len);
    logic [7:0] b;
    bus_wr(u, R_CTRL, {len, sa});
    for (int i = 0; i < int'(len); i++) begin
      b = rom_byte(sa + 16'(i));
      exp_q.push_back(b);
      m_sum = m_sum + {8'h0, b};
    end
  endtask

  task automatic drain(input int u, input int n);
    logic [31:0] d;
    int got, tries;
    got = 0; tries = 0;
    while (got < n && tries < n * 12 + 60) begin
      bus_rd(u, R_DATA, d);
      tries++;
      if (d[8]) begin
        got++;
        if (exp_q.size() == 0) chk("extra_byte", d, 32'h0);
        else                   chk("data", d, {23'h0, 1'b1, exp_q.pop_front()});
      end else begin
        chk("empty_word", d, 32'h0);
      end
    end
    chk("drain_count", got, n);
  endtask

  task automatic wait_idle(input int u, input int bound, output int k);
    logic [31:0] d;
    k = 0;
    do begin
      bus_rd(u, R_STATUS, d);
      k++;
    end while (d[0] && k < bound);
    if (d[0]) chk("busy_timeout", {31'h0, d[0]}, 32'h0);
  endtask

  task automatic reset_unit(input int u);
    rst[u] = 1'b1;
    #1;
    chk("rst_rom_rd", {31'h0, rom_rd[u]}, 32'h0);
    chk("rst_rom_addr", {16'h0, rom_addr[u]}, 32'h0);
    chk("rst_rdata", a_rdata[u], 32'h0);
    idle(2);
    rst[u] = 1'b0;
    idle(1);
    exp_q.delete();
    m_sum = 16'h0;
  endtask

  task automatic run_unit(input int u);
    logic [31:0] d;
    logic [15:0] sa;
    int lat, k, base, n0, len, guard;
    logic found;
    cur_u = u;
    lat   = (u == 0) ? 1 : 3;

    // Reset state
    reset_unit(u);
    bus_rd(u, R_STATUS, d); chk("rst_status", d, 32'h2);
    bus_rd(u, R_CTRL, d);   chk("rst_ctrl", d, 32'h0);
    bus_rd(u, R_CKSUM, d);  chk("rst_cksum", d, 32'h0);
    bus_rd(u, R_DATA, d);   chk("rst_data", d, 32'h0);

    // Sequential readback, BUSY timing
    ck_clear(u);
    start(u, 16'h8000, 16'd4);
    wait_idle(u, 200, k);
    chk("busy_drop", k, (lat + 1) * 4 + 1);
    bus_rd(u, R_STATUS, d); chk("seq_status", d, 32'h0400);
    chk("rom_addr_hold", {16'h0, rom_addr[u]}, 32'h8003);
    drain(u, 4);
    bus_rd(u, R_CKSUM, d);  chk("seq_cksum", d, exp_ck(m_sum));
    bus_rd(u, R_DATA, d);   chk("seq_empty", d, 32'h0);

    // Back-pressure
    ck_clear(u);
    sa   = 16'($urandom);
    base = rd_pulses[u];
    start(u, sa, 16'd20);
    idle(20 * (lat + 1) + 30);
    chk("bp_pulses", rd_pulses[u] - base, DEPTH);
    bus_rd(u, R_STATUS, d); chk("bp_status", d, (DEPTH << 8) | 32'h5);
    drain(u, 20);
    wait_idle(u, 200, k);
    chk("bp_pulses_all", rd_pulses[u] - base, 20);
    bus_rd(u, R_STATUS, d); chk("bp_status_end", d, 32'h2);
    bus_rd(u, R_CKSUM, d);  chk("bp_cksum", d, exp_ck(m_sum));

    // Address wrap
    n0 = iss_n[u];
    start(u, 16'hFFFE, 16'd4);
    wait_idle(u, 200, k);
    for (int i = 0; i < 4; i++) chk("wrap_addr", {16'h0, iss_log[u][(n0 + i) % 64]}, {16'h0, 16'hFFFE + 16'(i)});
    bus_rd(u, R_CTRL, d);   chk("wrap_ctrl", d, 32'h0000_0002);
    drain(u, 4);

    // CTRL write while busy, ERR handling, DATA write ignored
    sa   = 16'($urandom);
    base = rd_pulses[u];
    start(u, sa, 16'd6);
    idle(2);
    bus_wr(u, R_CTRL, {16'd3, 16'h1234});
    bus_rd(u, R_STATUS, d);
    chk("err_busy", {31'h0, d[0]}, 32'h1);
    chk("err_set", {31'h0, d[3]}, 32'h1);
    drain(u, 6);
    wait_idle(u, 200, k);
    chk("err_pulses", rd_pulses[u] - base, 6);
    bus_rd(u, R_CTRL, d);   chk("err_ctrl", d, {16'h0, sa + 16'd6});
    bus_rw(u, R_STATUS, 32'h0, d); chk("rw_status", d, 32'h0A);
    bus_rd(u, R_STATUS, d); chk("err_clr", d, 32'h2);
    bus_wr(u, R_DATA, 32'h1FF);
    bus_rd(u, R_STATUS, d); chk("data_wr_ign", d, 32'h2);
    bus_rd(u, R_DATA, d);   chk("empty_data", d, 32'h0);

    // Reset in the middle of a transfer
    ck_clear(u);
    base  = rd_pulses[u];
    start(u, 16'($urandom), 16'd10);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (rom_rd[u] && (rd_pulses[u] - base) >= 2) found = 1'b1;
    end
    chk("mid_found", {31'h0, found}, 32'h1);
    @(negedge clk);
    reset_unit(u);
    bus_rd(u, R_STATUS, d); chk("mid_status", d, 32'h2);
    bus_rd(u, R_CKSUM, d);  chk("mid_cksum", d, 32'h0);
    bus_rd(u, R_CTRL, d);   chk("mid_ctrl", d, 32'h0);
    start(u, 16'($urandom), 16'd3);
    drain(u, 3);
    wait_idle(u, 200, k);
    bus_rd(u, R_CKSUM, d);  chk("mid_cksum2", d, exp_ck(m_sum));

    // Randomized transfers with random drain pacing
    ck_clear(u);
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 24);
      start(u, 16'($urandom), 16'(len));
      guard = 0;
      while (exp_q.size() > 0 && guard < 2000) begin
        guard++;
        if ($urandom_range(0, 3) == 0) begin
          idle(1);
        end else begin
          bus_rd(u, R_DATA, d);
          if (d[8]) chk("rnd_data", d, {23'h0, 1'b1, exp_q.pop_front()});
          else      chk("rnd_empty", d, 32'h0);
        end
      end
      chk("rnd_left", exp_q.size(), 0);
      wait_idle(u, 200, k);
      bus_rd(u, R_STATUS, d); chk("rnd_status", d, 32'h2);
    end
    bus_rd(u, R_CKSUM, d);  chk("rnd_cksum", d, exp_ck(m_sum));
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1; a_addr[u] = 2'd0; a_cs[u] = 1'b0; a_rd[u] = 1'b0;
      a_wr[u] = 1'b0; a_wd[u] = 32'h0; rd_pulses[u] = 0; iss_n[u] = 0;
    end
    m_sum = 16'h0;
    idle(3);
    for (int u = 0; u < NU; u++) run_unit(u);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
